// File: rtl/booth_pp_accumulator_pkg.sv
// Shared definitions for the Booth partial-product accumulator.
//
// Holds the default operand/slot/accumulator/counter sizes, the product-width
// derivation and the accumulator FSM state encodings.
package booth_pp_accumulator_pkg;

    localparam int unsigned DEF_WIDTH_DATA   = 8;
    localparam int unsigned DEF_NUM_PP_SLOTS = 8;
    localparam int unsigned DEF_PW           = 2 * DEF_WIDTH_DATA;
    localparam int unsigned DEF_ACC_WIDTH    = DEF_PW + 8;
    localparam int unsigned DEF_CNT_WIDTH    = 16;

    // Accumulator FSM encodings
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    // Product width for a given operand width
    function automatic int unsigned pw_of(input int unsigned width_data);
        return 2 * width_data;
    endfunction

endpackage

// File: rtl/booth_pp_accumulator_pp_adder_tree.sv
// pp_adder_tree: reduces the Booth partial products to a single signed product.
//
// A capture register takes the bus (unused slots forced to zero), then stage S1
// registers the pairwise slot sums and stage S2 registers their total. All
// arithmetic wraps modulo 2^PW. Every register loads only while en=1.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears all valids and data)
//   en         pipeline advance
//   in_pp      packed partial products, slot i = in_pp[i*PW +: PW]
//   in_valid   in_pp/in_last valid
//   in_last    beat closes the current window
//   out_prod   signed product (PW bits)
//   out_valid  out_prod valid
//   out_last   last flag travelling with out_prod
module pp_adder_tree
    import booth_pp_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH_DATA   = DEF_WIDTH_DATA,
    parameter int unsigned NUM_PP_SLOTS = DEF_NUM_PP_SLOTS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic [2*WIDTH_DATA*NUM_PP_SLOTS-1:0]  in_pp,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic [2*WIDTH_DATA-1:0]               out_prod,
    output logic                                  out_valid,
    output logic                                  out_last
);

    localparam int unsigned PW       = pw_of(WIDTH_DATA);
    localparam int unsigned BusW     = PW * NUM_PP_SLOTS;
    // Radix-4 Booth yields WIDTH_DATA/2 partial products; the rest are ignored
    localparam int unsigned NumUsed  = (WIDTH_DATA / 2 < NUM_PP_SLOTS) ?
                                       WIDTH_DATA / 2 : NUM_PP_SLOTS;
    localparam int unsigned NumPairs = NUM_PP_SLOTS / 2;

    logic [BusW-1:0] pp_masked;
    logic [BusW-1:0] cap_pp_q;
    logic            cap_valid_q;
    logic            cap_last_q;

    logic [PW-1:0]   s1_d [NumPairs];
    logic [PW-1:0]   s1_q [NumPairs];
    logic            s1_valid_q;
    logic            s1_last_q;

    logic [PW-1:0]   prod_d;
    logic [PW-1:0]   prod_q;
    logic            prod_valid_q;
    logic            prod_last_q;

    always_comb begin
        pp_masked = '0;
        for (int unsigned i = 0; i < NumUsed; i++) begin
            pp_masked[i*PW +: PW] = in_pp[i*PW +: PW];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NumPairs; k++) begin
            s1_d[k] = cap_pp_q[(2*k)*PW +: PW] + cap_pp_q[(2*k+1)*PW +: PW];
        end
    end

    always_comb begin
        prod_d = '0;
        for (int unsigned k = 0; k < NumPairs; k++) begin
            prod_d = prod_d + s1_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pp_q     <= '0;
            cap_valid_q  <= 1'b0;
            cap_last_q   <= 1'b0;
            s1_q         <= '{default: '0};
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_last_q  <= 1'b0;
        end else if (en) begin
            cap_pp_q     <= pp_masked;
            cap_valid_q  <= in_valid;
            // last only has meaning on a valid beat
            cap_last_q   <= in_valid & in_last;
            s1_q         <= s1_d;
            s1_valid_q   <= cap_valid_q;
            s1_last_q    <= cap_last_q;
            prod_q       <= prod_d;
            prod_valid_q <= s1_valid_q;
            prod_last_q  <= s1_last_q;
        end
    end

    assign out_prod  = prod_q;
    assign out_valid = prod_valid_q;
    assign out_last  = prod_last_q;

endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: reduces Booth partial products to a signed product and
// accumulates products over a kernel window delimited by in_last, emitting one
// signed sum (and beat count) per window over a valid/ready handshake.
//
// Optional feature macro: ACC_SAT_EN. When defined the accumulator saturates to
// the signed ACC_WIDTH range, stays clamped until the window closes, and the
// extra output out_sat flags a window in which any add clipped. Otherwise the
// accumulator wraps and out_sat does not exist.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_pp      packed partial products (PW*NUM_PP_SLOTS)
//   in_valid   in_pp/in_last valid
//   in_last    beat closes the current window
//   in_ready   a beat is accepted this cycle when in_valid & in_ready
//   out_data   signed window sum (ACC_WIDTH)
//   out_beats  beats in the reported window (CNT_WIDTH, saturating)
//   out_valid  out_data/out_beats valid
//   out_ready  downstream accepts the result
//   out_sat    (ACC_SAT_EN only) window sum was clipped
module booth_pp_accumulator
    import booth_pp_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH_DATA   = DEF_WIDTH_DATA,
    parameter int unsigned NUM_PP_SLOTS = DEF_NUM_PP_SLOTS,
    parameter int unsigned ACC_WIDTH    = 2 * WIDTH_DATA + 8,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [2*WIDTH_DATA*NUM_PP_SLOTS-1:0]  in_pp,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    output logic                                  in_ready,
    output logic [ACC_WIDTH-1:0]                  out_data,
    output logic [CNT_WIDTH-1:0]                  out_beats,
    output logic                                  out_valid,
    input  logic                                  out_ready
`ifdef ACC_SAT_EN
    ,
    output logic                                  out_sat
`endif
);

    localparam int unsigned PW     = pw_of(WIDTH_DATA);
    localparam int unsigned AccMsb = ACC_WIDTH - 1;

    logic                 adv;
    logic [PW-1:0]        prod;
    logic                 prod_valid;
    logic                 prod_last;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH-1:0] sum;

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] out_beats_q, out_beats_d;

`ifdef ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic ovf;
    logic win_sat_q, win_sat_d;
    logic out_sat_q, out_sat_d;
`endif

    // Whole pipeline freezes while a result is held unaccepted
    assign adv      = ~(out_valid_q & ~out_ready);
    assign in_ready = adv;

    pp_adder_tree #(
        .WIDTH_DATA   (WIDTH_DATA),
        .NUM_PP_SLOTS (NUM_PP_SLOTS)
    ) u_pp_adder_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_pp     (in_pp),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .out_prod  (prod),
        .out_valid (prod_valid),
        .out_last  (prod_last)
    );

    assign p_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign sum   = acc_q + p_ext;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
`ifdef ACC_SAT_EN
        win_sat_d   = win_sat_q;
        out_sat_d   = out_sat_q;
        // Signed overflow: operands agree in sign, result does not
        ovf         = (acc_q[AccMsb] == p_ext[AccMsb]) && (sum[AccMsb] != acc_q[AccMsb]);
`endif

        if (adv) begin
            // adv in HOLD means the held result is being taken this cycle
            if (state_q == StHold) begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end

            if (prod_valid) begin
                if (state_q == StAccum) begin
`ifdef ACC_SAT_EN
                    if (win_sat_q) begin
                        acc_d = acc_q;
                    end else if (ovf) begin
                        acc_d     = acc_q[AccMsb] ? AccMin : AccMax;
                        win_sat_d = 1'b1;
                    end else begin
                        acc_d = sum;
                    end
`else
                    acc_d = sum;
`endif
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                end else begin
                    // IDLE, or HOLD handing over straight into a new window
                    acc_d = p_ext;
                    cnt_d = CNT_WIDTH'(1);
`ifdef ACC_SAT_EN
                    win_sat_d = 1'b0;
`endif
                end

                if (prod_last) begin
                    state_d     = StHold;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_d;
                    out_beats_d = cnt_d;
`ifdef ACC_SAT_EN
                    out_sat_d   = win_sat_d;
`endif
                end else begin
                    state_d = StAccum;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
`ifdef ACC_SAT_EN
            win_sat_q   <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
`ifdef ACC_SAT_EN
            win_sat_q   <= win_sat_d;
            out_sat_q   <= out_sat_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;
`ifdef ACC_SAT_EN
    assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Bench for booth_pp_accumulator: table-driven single-beat windows, hand-written
// multi-cycle sequences and randomized windows, all checked against a
// window-level arithmetic model of the expected results.
module tb_booth_pp_accumulator;

    localparam int WD = 8;
    localparam int NS = 8;
    localparam int PW = 2 * WD;
    localparam int AW = 2 * WD + 8;
    localparam int CW = 16;
    localparam int BW = PW * NS;

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] in_pp;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_beats;
    logic          out_valid;
    logic          out_ready;
`ifdef ACC_SAT_EN
    logic          out_sat;
`endif

    always #5 clk = ~clk;

    booth_pp_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_pp     (in_pp),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_beats (out_beats),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ACC_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stall_left = 0;
    bit rand_ready = 0;
    bit saw_stall  = 0;

    // Reference model state: running window and expected results
    longint        m_sum;
    int            m_cnt = 0;
    bit            m_sat;
    logic [AW-1:0] exp_data[$];
    int            exp_beats[$];
    bit            exp_sat[$];

    // Observed accepted results
    int            fire_cyc[$];
    logic [AW-1:0] fire_data[$];
    int            fire_beats[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [BW-1:0] mk_bus(input logic [PW-1:0] a, b, c, d, junk);
        return {junk, junk, junk, junk, d, c, b, a};
    endfunction

    function automatic logic [BW-1:0] pp_of(input logic [PW-1:0] p);
        return mk_bus(p, '0, '0, '0, '0);
    endfunction

    // Product is the four used slots summed modulo 2^PW, read as signed
    task automatic model_beat(input logic [BW-1:0] pp, input logic l);
        logic [PW-1:0] p;
        longint        pv;
        longint        t;
        longint        maxv;
        longint        minv;
        p    = pp[0 +: PW] + pp[PW +: PW] + pp[2*PW +: PW] + pp[3*PW +: PW];
        pv   = longint'($signed(p));
        maxv = (longint'(1) <<< (AW - 1)) - 1;
        minv = -(longint'(1) <<< (AW - 1));
        if (m_cnt == 0) begin
            m_sum = pv;
            m_cnt = 1;
            m_sat = 0;
        end else begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            t = m_sum + pv;
`ifdef ACC_SAT_EN
            if (!m_sat) begin
                if (t > maxv) begin
                    m_sum = maxv;
                    m_sat = 1;
                end else if (t < minv) begin
                    m_sum = minv;
                    m_sat = 1;
                end else begin
                    m_sum = t;
                end
            end
`else
            m_sum = t;
`endif
        end
        if (l) begin
            exp_data.push_back(AW'(m_sum));
            exp_beats.push_back(m_cnt);
            exp_sat.push_back(m_sat);
            m_cnt = 0;
        end
    endtask

    // One clock: drive, sample mid-cycle, compare, then advance past the edge
    task automatic cycle(input logic v, input logic [BW-1:0] pp, input logic l, output logic acc);
        in_valid  = v;
        in_pp     = pp;
        in_last   = l;
        out_ready = (stall_left > 0) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        #2;
        check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (!in_ready) saw_stall = 1;
        if (out_valid) begin
            if (exp_data.size() == 0) begin
                check("spurious_out_valid", out_valid, 1'b0);
            end else begin
                check("out_data", out_data, exp_data[0]);
                check("out_beats", out_beats, exp_beats[0]);
`ifdef ACC_SAT_EN
                check("out_sat", out_sat, exp_sat[0]);
`endif
                if (out_ready) begin
                    fire_cyc.push_back(cyc);
                    fire_data.push_back(out_data);
                    fire_beats.push_back(out_beats);
                    void'(exp_data.pop_front());
                    void'(exp_beats.pop_front());
                    void'(exp_sat.pop_front());
                end
            end
        end
        acc = v & in_ready;
        if (acc) model_beat(pp, l);
        if (stall_left > 0) stall_left--;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Offer a beat until accepted; ac is the cycle in which it was accepted
    task automatic send(input logic [BW-1:0] pp, input logic l, output int ac);
        logic a;
        a  = 0;
        ac = -1;
        for (int k = 0; k < 50 && !a; k++) begin
            cycle(1'b1, pp, l, a);
            if (a) ac = cyc - 1;
        end
        if (!a) check("send_timeout", 1'b0, 1'b1);
    endtask

    // Idle cycles with random junk on the (invalid) inputs
    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), a);
        end
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 200 && exp_data.size() > 0; k++) cycle(1'b0, '0, 1'b0, a);
        check("drain_timeout", exp_data.size(), 0);
        idle(4);
    endtask

    task automatic clear_fires();
        fire_cyc.delete();
        fire_data.delete();
        fire_beats.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        exp_data.delete();
        exp_beats.delete();
        exp_sat.delete();
        m_cnt = 0;
        out_ready = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);
        check("reset_out_beats", out_beats, '0);
        check("reset_in_ready", in_ready, 1'b1);
`ifdef ACC_SAT_EN
        check("reset_out_sat", out_sat, 1'b0);
`endif
    endtask

    typedef struct {
        logic [PW-1:0] s0, s1, s2, s3, junk;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        int last_ac;
        logic [BW-1:0] bus;

        vecs[0] = '{16'h0005, 16'h000A, 16'h0000, 16'h0000, 16'h0000, 24'h00000F};
        vecs[1] = '{16'hFFFB, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 24'hFFFFFB};
        vecs[2] = '{16'h0100, 16'hFF00, 16'h0010, 16'h0003, 16'h0000, 24'h000013};
        vecs[3] = '{16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 24'hFF8000};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 24'h001234};
        vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 24'h000000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1111, 24'hFFFFFC};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_pp = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single-beat windows: value, count and three-edge latency
        for (int i = 0; i < 7; i++) begin
            clear_fires();
            bus = mk_bus(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].junk);
            send(bus, 1'b1, ac);
            drain();
            check($sformatf("vec%0d_count", i), fire_data.size(), 1);
            if (fire_data.size() == 1) begin
                check($sformatf("vec%0d_data", i), fire_data[0], vecs[i].exp);
                check($sformatf("vec%0d_beats", i), fire_beats[0], 1);
                check($sformatf("vec%0d_latency", i), fire_cyc[0], ac + 4);
            end
        end

        // Four-beat window: 15, -5, 100, 2
        clear_fires();
        send(pp_of(16'd15), 1'b0, ac);
        send(pp_of(16'hFFFB), 1'b0, ac);
        send(pp_of(16'd100), 1'b0, ac);
        send(pp_of(16'd2), 1'b1, last_ac);
        drain();
        check("win4_count", fire_data.size(), 1);
        if (fire_data.size() == 1) begin
            check("win4_data", fire_data[0], 24'd112);
            check("win4_beats", fire_beats[0], 4);
            check("win4_latency", fire_cyc[0], last_ac + 4);
        end

        // Back-to-back single-beat windows 7, 9, 11
        clear_fires();
        send(pp_of(16'd7), 1'b1, ac);
        send(pp_of(16'd9), 1'b1, ac);
        send(pp_of(16'd11), 1'b1, ac);
        drain();
        check("b2b_count", fire_data.size(), 3);
        if (fire_data.size() == 3) begin
            check("b2b_data0", fire_data[0], 24'd7);
            check("b2b_data1", fire_data[1], 24'd9);
            check("b2b_data2", fire_data[2], 24'd11);
            check("b2b_gap01", fire_cyc[1], fire_cyc[0] + 1);
            check("b2b_gap12", fire_cyc[2], fire_cyc[1] + 1);
        end

        // Back-pressure: held result stalls 6 offered beats for 5 cycles
        clear_fires();
        send(pp_of(16'd1), 1'b1, ac);
        idle(2);
        stall_left = 5;
        saw_stall  = 0;
        for (int b = 0; b < 6; b++) send(pp_of(16'(b + 3)), b == 5, ac);
        drain();
        check("bp_in_ready_dropped", saw_stall, 1'b1);
        check("bp_count", fire_data.size(), 2);
        if (fire_data.size() == 2) begin
            check("bp_first", fire_data[0], 24'd1);
            check("bp_second", fire_data[1], 24'd33);
            check("bp_second_beats", fire_beats[1], 6);
        end

        // Reset mid-window discards the partial sum
        clear_fires();
        send(pp_of(16'd15), 1'b0, ac);
        send(pp_of(16'd15), 1'b0, ac);
        idle(3);
        do_reset();
        send(pp_of(16'd3), 1'b1, ac);
        drain();
        check("rst_mid_count", fire_data.size(), 1);
        if (fire_data.size() == 1) begin
            check("rst_mid_data", fire_data[0], 24'd3);
            check("rst_mid_beats", fire_beats[0], 1);
        end

`ifdef ACC_SAT_EN
        // Saturation: 300 beats of 0x7FFF clamp to the positive limit
        clear_fires();
        for (int b = 0; b < 300; b++) send(pp_of(16'h7FFF), b == 299, ac);
        drain();
        check("sat_count", fire_data.size(), 1);
        if (fire_data.size() == 1) begin
            check("sat_data", fire_data[0], 24'h7FFFFF);
            check("sat_beats", fire_beats[0], 300);
        end
`endif

        // Randomized windows with random gaps and random out_ready
        rand_ready = 1;
        for (int w = 0; w < 40; w++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                bus = {$urandom, $urandom, $urandom, $urandom};
                send(bus, b == len - 1, ac);
            end
        end
        drain();
        rand_ready = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_pp_accumulator.md
Name: booth_pp_accumulator

Overview:
- Consumes the packed partial-product bus from the Booth encoder in the conv1d datapath.
- Reduces the partial products to one signed product in a two-stage adder tree.
- Accumulates products across a kernel window and emits one signed sum per window, delimited by in_last.
- Output drives the conv1d bias/activation stage through a valid/ready handshake.

Parameters:
- WIDTH_DATA, 8, operand width. Product width is PW = 2*WIDTH_DATA.
- NUM_PP_SLOTS, 8, slots in the input bus. Slots 0..WIDTH_DATA/2-1 are used; higher slots are ignored and treated as zero.
- ACC_WIDTH, 2*WIDTH_DATA+8, accumulator and output width (signed).
- CNT_WIDTH, 16, width of the beat counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_pp  in  PW*NUM_PP_SLOTS  packed partial products; slot i = in_pp[i*PW +: PW], two's complement
- in_valid  in  1  in_pp/in_last valid
- in_last  in  1  beat closes the current kernel window
- in_ready  out  1  block accepts a beat this cycle
- out_data  out  ACC_WIDTH  signed window sum
- out_beats  out  CNT_WIDTH  number of beats in the reported window
- out_valid  out  1  out_data/out_beats valid
- out_ready  in  1  downstream accepts the result

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): all pipeline valids=0, out_valid=0, out_data=0, out_beats=0, accumulator=0, beat counter=0, state=IDLE. Reset mid-window discards the partial window and any held output.
- Global stall: adv = ~(out_valid & ~out_ready). in_ready = adv. All stage registers load only when adv=1.
- An input beat is accepted when in_valid & in_ready.
- Stage S1 (register): four pairwise sums s_k = slot(2k) + slot(2k+1), modulo 2^PW.
- Stage S2 (register): product = s0+s1+s2+s3 modulo 2^PW. This is the exact signed WIDTH_DATA x WIDTH_DATA product. The last flag travels alongside the data.
- Stage S3 (accumulator FSM), with p_ext = product sign-extended to ACC_WIDTH:
  - IDLE: on a valid S2 beat, acc <= p_ext and cnt <= 1. If the beat is last, go to HOLD; else go to ACCUM.
  - ACCUM: on a valid S2 beat, acc <= acc + p_ext and cnt <= cnt + 1. If the beat is last, go to HOLD.
  - Entering HOLD loads the updated acc into out_data and cnt into out_beats, and sets out_valid=1.
  - HOLD: when out_ready=1, out_valid drops the next cycle unless a new last beat reaches S3 in that same cycle (back-to-back single-beat windows).
  - Leaving HOLD takes the new S2 beat into IDLE/ACCUM semantics in the same cycle, so there are no bubbles when out_ready is held high.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N+3.
- Throughput: one beat per clock while out_ready=1.
- Arithmetic: the accumulator wraps modulo 2^ACC_WIDTH (unless ACC_SAT_EN). The beat counter saturates at 2^CNT_WIDTH-1.
- out_data and out_beats stay stable while out_valid & ~out_ready.
- A window of a single beat (in_last on the first beat) is legal: out_data equals that product.
- in_last is ignored when in_valid=0.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: the accumulator add saturates to the signed range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Once saturated, it stays clamped until the window ends. An extra output out_sat (1 bit) is asserted with out_valid if any add in the window clipped; it is reset to 0.
- Not defined: wrap-around arithmetic; the out_sat port is absent.

Decomposition:
- Shared define header holds WIDTH_DATA, NUM_PP_SLOTS, the PW derivation, the default ACC_WIDTH, and the state encodings IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
- Sub-module pp_adder_tree implements stages S1-S2: parameter WIDTH_DATA; ports clk, rst, en, in_pp, in_valid, in_last, out_prod, out_valid, out_last.
- The accumulator FSM and handshake stay in the top level.

Test Plan (WIDTH_DATA=8):
- Single beat: slot0=16'h0005, slot1=16'h000A, other slots 0, in_last=1 -> 3 cycles later out_valid=1, out_data=15, out_beats=1.
- Negative product: slot0=16'hFFFB, others 0, last -> out_data=-5 (24'hFFFFFB), out_beats=1.
- Window of 4 beats: products 15, -5, 100, 2, last on beat 4 -> one result, out_data=112, out_beats=4. No out_valid before the fourth beat.
- Back-pressure: out_ready=0 for 5 cycles while 6 beats are offered -> in_ready drops when the pipe is full, no beat is lost or duplicated, and out_data stays stable. Releasing out_ready gives the correct next window sum.
- Back-to-back last beats with products 7, 9, 11 and out_ready=1 -> three consecutive out_valid cycles with out_data 7, 9, 11.
- Reset mid-window after 2 beats (15, 15), then one last beat of 3 -> out_data=3, out_beats=1. With ACC_SAT_EN, 300 beats of product 16'h7FFF -> out_data=24'h7FFFFF and out_sat=1.
